// File: rtl/regbank_arb_pkg.sv
// Shared types and constants for the register-bank write arbiter.
package regbank_arb_pkg;

    localparam int unsigned NREG_C = 16;
    localparam int unsigned DW_C   = 32;
    localparam int unsigned AW_C   = 4;
    localparam int unsigned PC_IDX = 15;

    typedef struct packed {
        logic [AW_C-1:0] addr;
        logic [DW_C-1:0] data;
    } wr_req_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_A,
        GNT_B
    } gnt_e;

    // Which held slot arrived first when they were loaded on different cycles.
    typedef enum logic {
        AGE_A_OLDER,
        AGE_B_OLDER
    } age_e;

endpackage

// File: rtl/regbank_arb_slot.sv
// One-deep holding slot for a writeback source: valid/ready handshake,
// empties on grant, and can reload on the same edge it is granted.
module regbank_arb_slot #(
    parameter int unsigned AW = 4,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [AW-1:0] in_addr,
    input  logic [DW-1:0] in_data,
    input  logic          grant,
    output logic          ready,
    output logic          load,
    output logic          full,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] data
);

    logic          full_q, full_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;

    assign ready = !full_q || grant;
    assign load  = in_valid && ready;
    assign full  = full_q;
    assign addr  = addr_q;
    assign data  = data_q;

    // Next slot contents: a load wins over the grant that frees the slot.
    always_comb begin
        full_d = full_q;
        addr_d = addr_q;
        data_d = data_q;
        if (grant) begin
            full_d = 1'b0;
        end
        if (load) begin
            full_d = 1'b1;
            addr_d = in_addr;
            data_d = in_data;
        end
    end

    // Slot state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/regbank_wr_arbiter.sv
// Arbitrates the single register-bank write port between the ALU (A) and
// load-return (B) writeback sources, issuing in arrival order.
// Optional feature macro: REGBANK_ARB_SCOREBOARD_EN enables the pendMask
// scoreboard; when undefined pendMask is tied to zero.
module regbank_wr_arbiter
    import regbank_arb_pkg::*;
#(
    parameter int unsigned NREG = NREG_C,
    parameter int unsigned DW   = DW_C,
    parameter int unsigned AW   = AW_C
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            aValid,
    input  logic [AW-1:0]   aAddr,
    input  logic [DW-1:0]   aData,
    output logic            aReady,
    input  logic            bValid,
    input  logic [AW-1:0]   bAddr,
    input  logic [DW-1:0]   bData,
    output logic            bReady,
    output logic            regWr,
    output logic [AW-1:0]   addWr,
    output logic [DW-1:0]   diWr,
    output logic            wrPc,
    output logic [NREG-1:0] pendMask
);

    logic          a_load, a_full, a_grant;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_data;
    logic          b_load, b_full, b_grant;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_data;

    gnt_e          gnt;
    logic          rr_q, rr_d;
    age_e          age_q, age_d;
    logic          same_q, same_d;

    logic          regwr_q, regwr_d;
    logic [AW-1:0] addwr_q, addwr_d;
    logic [DW-1:0] diwr_q, diwr_d;
    logic          wrpc_q, wrpc_d;

    regbank_arb_slot #(.AW(AW), .DW(DW)) u_slot_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (aValid),
        .in_addr  (aAddr),
        .in_data  (aData),
        .grant    (a_grant),
        .ready    (aReady),
        .load     (a_load),
        .full     (a_full),
        .addr     (a_addr),
        .data     (a_data)
    );

    regbank_arb_slot #(.AW(AW), .DW(DW)) u_slot_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (bValid),
        .in_addr  (bAddr),
        .in_data  (bData),
        .grant    (b_grant),
        .ready    (bReady),
        .load     (b_load),
        .full     (b_full),
        .addr     (b_addr),
        .data     (b_data)
    );

    // Grant selection: single full slot wins; with both full, age decides,
    // or the round-robin pointer when both were loaded on the same edge.
    always_comb begin
        gnt  = GNT_NONE;
        rr_d = rr_q;
        if (a_full && b_full) begin
            if (same_q) begin
                gnt = rr_q ? GNT_B : GNT_A;
            end else begin
                gnt = (age_q == AGE_B_OLDER) ? GNT_B : GNT_A;
            end
            rr_d = ~rr_q;
        end else if (a_full) begin
            gnt = GNT_A;
        end else if (b_full) begin
            gnt = GNT_B;
        end
    end

    assign a_grant = (gnt == GNT_A);
    assign b_grant = (gnt == GNT_B);

    // Arrival-order tracking between the two slots.
    always_comb begin
        age_d  = age_q;
        same_d = same_q;
        if (a_load && b_load) begin
            same_d = 1'b1;
        end else if (a_load && b_full && !b_grant) begin
            age_d  = AGE_B_OLDER;
            same_d = 1'b0;
        end else if (b_load && a_full && !a_grant) begin
            age_d  = AGE_A_OLDER;
            same_d = 1'b0;
        end
    end

    // Issue register next state: granted slot drives the bank port,
    // otherwise the port goes idle while address/data hold.
    always_comb begin
        regwr_d = 1'b1;
        wrpc_d  = 1'b0;
        addwr_d = addwr_q;
        diwr_d  = diwr_q;
        case (gnt)
            GNT_A: begin
                regwr_d = 1'b0;
                addwr_d = a_addr;
                diwr_d  = a_data;
                wrpc_d  = (a_addr == AW'(PC_IDX));
            end
            GNT_B: begin
                regwr_d = 1'b0;
                addwr_d = b_addr;
                diwr_d  = b_data;
                wrpc_d  = (b_addr == AW'(PC_IDX));
            end
            default: begin
                regwr_d = 1'b1;
            end
        endcase
    end

    // Arbitration state and issue register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q    <= 1'b0;
            age_q   <= AGE_A_OLDER;
            same_q  <= 1'b0;
            regwr_q <= 1'b1;
            addwr_q <= '0;
            diwr_q  <= '0;
            wrpc_q  <= 1'b0;
        end else begin
            rr_q    <= rr_d;
            age_q   <= age_d;
            same_q  <= same_d;
            regwr_q <= regwr_d;
            addwr_q <= addwr_d;
            diwr_q  <= diwr_d;
            wrpc_q  <= wrpc_d;
        end
    end

    assign regWr = regwr_q;
    assign addWr = addwr_q;
    assign diWr  = diwr_q;
    assign wrPc  = wrpc_q;

`ifdef REGBANK_ARB_SCOREBOARD_EN
    logic [NREG-1:0] pend_q, pend_d;

    // Pending mask built from next-state slot and issue contents, so the
    // registered value is exact in the cycle it is observed.
    always_comb begin
        pend_d = '0;
        if (a_load) begin
            pend_d[aAddr] = 1'b1;
        end else if (a_full && !a_grant) begin
            pend_d[a_addr] = 1'b1;
        end
        if (b_load) begin
            pend_d[bAddr] = 1'b1;
        end else if (b_full && !b_grant) begin
            pend_d[b_addr] = 1'b1;
        end
        if (!regwr_d) begin
            pend_d[addwr_d] = 1'b1;
        end
    end

    // Pending mask register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pendMask = pend_q;
`else
    assign pendMask = '0;
`endif

endmodule

// File: tb/tb_regbank_wr_arbiter.sv
// Directed self-checking bench for regbank_wr_arbiter.
module tb_regbank_wr_arbiter;

`ifdef REGBANK_ARB_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        aValid, bValid;
    logic [3:0]  aAddr, bAddr;
    logic [31:0] aData, bData;
    logic        aReady, bReady;
    logic        regWr, wrPc;
    logic [3:0]  addWr;
    logic [31:0] diWr;
    logic [15:0] pendMask;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    regbank_wr_arbiter #(.NREG(16), .DW(32), .AW(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .aValid   (aValid),
        .aAddr    (aAddr),
        .aData    (aData),
        .aReady   (aReady),
        .bValid   (bValid),
        .bAddr    (bAddr),
        .bData    (bData),
        .bReady   (bReady),
        .regWr    (regWr),
        .addWr    (addWr),
        .diWr     (diWr),
        .wrPc     (wrPc),
        .pendMask (pendMask)
    );

    always #5 clk = ~clk;

    // Expected pendMask for the configured build.
    function automatic logic [15:0] pe(input logic [15:0] m);
        return SB ? m : 16'h0000;
    endfunction

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        aValid = 1'b1; aAddr = 4'd4; aData = 32'hDEAD_BEEF;
        bValid = 1'b0; bAddr = 4'd0; bData = '0;
        cyc(); cyc(); cyc();
        n_vec++; if (regWr !== 1'b1) begin n_err++; $display("FAIL reset_regwr got %b want 1", regWr); end
        n_vec++; if (pendMask !== 16'h0) begin n_err++; $display("FAIL reset_pend got %h want 0000", pendMask); end
        n_vec++; if (addWr !== 4'd0 || diWr !== 32'h0 || wrPc !== 1'b0) begin n_err++; $display("FAIL reset_issue got a=%0d d=%h pc=%b want 0/0/0", addWr, diWr, wrPc); end
        aValid = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_vec++; if (regWr !== 1'b1) begin n_err++; $display("FAIL post_reset_idle[%0d] got regWr=%b want 1", i, regWr); end
        end
        n_vec++; if (aReady !== 1'b1 || bReady !== 1'b1) begin n_err++; $display("FAIL post_reset_ready got a=%b b=%b want 1/1", aReady, bReady); end
    endtask

    task automatic test_single_a();
        aValid = 1'b1; aAddr = 4'd3; aData = 32'h0000_00AA;
        cyc();
        aValid = 1'b0;
        n_vec++; if (regWr !== 1'b1) begin n_err++; $display("FAIL single_n regWr got %b want 1", regWr); end
        n_vec++; if (pendMask !== pe(16'h0008)) begin n_err++; $display("FAIL single_n pend got %h want %h", pendMask, pe(16'h0008)); end
        n_vec++; if (aReady !== 1'b1) begin n_err++; $display("FAIL single_n aReady got %b want 1", aReady); end
        cyc();
        n_vec++; if (regWr !== 1'b0 || addWr !== 4'd3 || diWr !== 32'hAA || wrPc !== 1'b0) begin n_err++; $display("FAIL single_issue got w=%b a=%0d d=%h pc=%b want 0/3/aa/0", regWr, addWr, diWr, wrPc); end
        n_vec++; if (pendMask !== pe(16'h0008)) begin n_err++; $display("FAIL single_issue pend got %h want %h", pendMask, pe(16'h0008)); end
        cyc();
        n_vec++; if (regWr !== 1'b1 || addWr !== 4'd3 || diWr !== 32'hAA) begin n_err++; $display("FAIL single_idle got w=%b a=%0d d=%h want 1/3/aa", regWr, addWr, diWr); end
        n_vec++; if (pendMask !== 16'h0) begin n_err++; $display("FAIL single_idle pend got %h want 0000", pendMask); end
    endtask

    task automatic test_same_cycle();
        logic [3:0]  fa [2];
        logic [31:0] fd [2];
        for (int rep = 0; rep < 2; rep++) begin
            // rr starts at 0: first pair A first, second pair B first.
            if (rep == 0) begin fa[0] = 4'd1; fd[0] = 32'h11; fa[1] = 4'd2; fd[1] = 32'h22; end
            else          begin fa[0] = 4'd2; fd[0] = 32'h22; fa[1] = 4'd1; fd[1] = 32'h11; end
            aValid = 1'b1; aAddr = 4'd1; aData = 32'h11;
            bValid = 1'b1; bAddr = 4'd2; bData = 32'h22;
            cyc();
            aValid = 1'b0; bValid = 1'b0;
            n_vec++; if (aReady !== (rep == 0) || bReady !== (rep == 1)) begin n_err++; $display("FAIL pair%0d_ready got a=%b b=%b want %b/%b", rep, aReady, bReady, rep == 0, rep == 1); end
            n_vec++; if (pendMask !== pe(16'h0006)) begin n_err++; $display("FAIL pair%0d_pend0 got %h want %h", rep, pendMask, pe(16'h0006)); end
            cyc();
            n_vec++; if (regWr !== 1'b0 || addWr !== fa[0] || diWr !== fd[0]) begin n_err++; $display("FAIL pair%0d_first got w=%b a=%0d d=%h want 0/%0d/%h", rep, regWr, addWr, diWr, fa[0], fd[0]); end
            n_vec++; if (pendMask !== pe(16'h0006)) begin n_err++; $display("FAIL pair%0d_pend1 got %h want %h", rep, pendMask, pe(16'h0006)); end
            cyc();
            n_vec++; if (regWr !== 1'b0 || addWr !== fa[1] || diWr !== fd[1]) begin n_err++; $display("FAIL pair%0d_second got w=%b a=%0d d=%h want 0/%0d/%h", rep, regWr, addWr, diWr, fa[1], fd[1]); end
            cyc();
            n_vec++; if (regWr !== 1'b1 || pendMask !== 16'h0) begin n_err++; $display("FAIL pair%0d_done got w=%b pend=%h want 1/0000", rep, regWr, pendMask); end
        end
    endtask

    task automatic test_order();
        // Same-edge A r7 / B r5=1 (rr=0, A issues first), then A r5=2 loads
        // while B r5=1 is still held: r5 must see 1 then 2.
        aValid = 1'b1; aAddr = 4'd7; aData = 32'h77;
        bValid = 1'b1; bAddr = 4'd5; bData = 32'h1;
        cyc();
        bValid = 1'b0;
        aAddr = 4'd5; aData = 32'h2;
        n_vec++; if (pendMask !== pe(16'h00A0)) begin n_err++; $display("FAIL order_pend0 got %h want %h", pendMask, pe(16'h00A0)); end
        cyc();
        aValid = 1'b0;
        n_vec++; if (regWr !== 1'b0 || addWr !== 4'd7 || diWr !== 32'h77) begin n_err++; $display("FAIL order_w0 got w=%b a=%0d d=%h want 0/7/77", regWr, addWr, diWr); end
        n_vec++; if (aReady !== 1'b0 || bReady !== 1'b1) begin n_err++; $display("FAIL order_ready got a=%b b=%b want 0/1", aReady, bReady); end
        n_vec++; if (pendMask !== pe(16'h00A0)) begin n_err++; $display("FAIL order_pend1 got %h want %h", pendMask, pe(16'h00A0)); end
        cyc();
        n_vec++; if (regWr !== 1'b0 || addWr !== 4'd5 || diWr !== 32'h1) begin n_err++; $display("FAIL order_w1 got w=%b a=%0d d=%h want 0/5/1", regWr, addWr, diWr); end
        n_vec++; if (pendMask !== pe(16'h0020)) begin n_err++; $display("FAIL order_pend2 got %h want %h", pendMask, pe(16'h0020)); end
        cyc();
        n_vec++; if (regWr !== 1'b0 || addWr !== 4'd5 || diWr !== 32'h2) begin n_err++; $display("FAIL order_w2 got w=%b a=%0d d=%h want 0/5/2", regWr, addWr, diWr); end
        n_vec++; if (pendMask !== pe(16'h0020)) begin n_err++; $display("FAIL order_pend3 got %h want %h", pendMask, pe(16'h0020)); end
        cyc();
        n_vec++; if (regWr !== 1'b1 || pendMask !== 16'h0) begin n_err++; $display("FAIL order_done got w=%b pend=%h want 1/0000", regWr, pendMask); end
    endtask

    task automatic test_pc();
        bValid = 1'b1; bAddr = 4'd15; bData = 32'h100;
        cyc();
        bValid = 1'b0;
        n_vec++; if (wrPc !== 1'b0 || regWr !== 1'b1) begin n_err++; $display("FAIL pc_pre got pc=%b w=%b want 0/1", wrPc, regWr); end
        cyc();
        n_vec++; if (wrPc !== 1'b1 || regWr !== 1'b0 || addWr !== 4'd15 || diWr !== 32'h100) begin n_err++; $display("FAIL pc_issue got pc=%b w=%b a=%0d d=%h want 1/0/15/100", wrPc, regWr, addWr, diWr); end
        n_vec++; if (pendMask !== pe(16'h8000)) begin n_err++; $display("FAIL pc_pend got %h want %h", pendMask, pe(16'h8000)); end
        cyc();
        n_vec++; if (wrPc !== 1'b0 || regWr !== 1'b1) begin n_err++; $display("FAIL pc_post got pc=%b w=%b want 0/1", wrPc, regWr); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] m;
        for (int k = 0; k < 8; k++) begin
            if (k >= 1) begin
                n_vec++; if (aReady !== 1'b1) begin n_err++; $display("FAIL b2b[%0d] aReady got %b want 1", k, aReady); end
            end
            if (k >= 2) begin
                n_vec++; if (regWr !== 1'b0 || addWr !== 4'(k + 2) || diWr !== 32'(32'hA0 + k - 2)) begin n_err++; $display("FAIL b2b[%0d] issue got w=%b a=%0d d=%h want 0/%0d/%h", k, regWr, addWr, diWr, k + 2, 32'hA0 + k - 2); end
                m = '0; m[k + 3] = 1'b1; m[k + 2] = 1'b1;
                n_vec++; if (pendMask !== pe(m)) begin n_err++; $display("FAIL b2b[%0d] pend got %h want %h", k, pendMask, pe(m)); end
            end else if (k == 1) begin
                n_vec++; if (regWr !== 1'b1) begin n_err++; $display("FAIL b2b[1] regWr got %b want 1", regWr); end
            end
            aValid = 1'b1; aAddr = 4'(k + 4); aData = 32'(32'hA0 + k);
            cyc();
        end
        n_vec++; if (regWr !== 1'b0 || addWr !== 4'd10 || diWr !== 32'hA6) begin n_err++; $display("FAIL b2b_tail got w=%b a=%0d d=%h want 0/10/a6", regWr, addWr, diWr); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (regWr !== 1'b1 || wrPc !== 1'b0) begin n_err++; $display("FAIL midreset_regwr got w=%b pc=%b want 1/0", regWr, wrPc); end
        n_vec++; if (aReady !== 1'b1 || bReady !== 1'b1 || pendMask !== 16'h0) begin n_err++; $display("FAIL midreset_slots got a=%b b=%b pend=%h want 1/1/0000", aReady, bReady, pendMask); end
        aValid = 1'b0;
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_vec++; if (regWr !== 1'b1) begin n_err++; $display("FAIL midreset_drop[%0d] regWr got %b want 1", i, regWr); end
        end
    endtask

    initial begin
        test_reset();
        test_single_a();
        test_same_cycle();
        test_order();
        test_pc();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
